// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator for decode.
//
// The instruction word is decoded combinationally on its opcode. The
// result goes into a main register M, which drives out_*, or into a skid
// register K when M is still waiting on the consumer. in_ready comes
// straight from a flop and depends only on the occupancy state, so there
// is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    in_inst is valid this cycle
//   in_ready    block can accept a word (registered)
//   in_inst     32-bit instruction word
//   out_valid   out_* fields are valid
//   out_ready   consumer accepts out_* this cycle
//   out_imm     sign-extended immediate, XLEN wide
//   out_fmt     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_illegal opcode not recognised
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } res_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [31:0] imm32;
    res_t        dec;

    assign opcode = in_inst[6:0];

    always_comb begin
        imm32 = '0;
        dec   = '0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0011011: begin
                if (RV64_OPS) begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b0110011: ;  // register-register: no immediate, legal
            7'b0111011: begin
                if (!RV64_OPS) dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // bit 31 of every 32-bit immediate is inst[31]; widen signed
        dec.imm = XLEN'($signed(imm32));
    end

    // ------------------------------------------------------------------
    // Two-entry skid control
    // ------------------------------------------------------------------
    state_t state, state_nx;
    res_t   m_q, k_q;
    logic   rdy_q;
    logic   accept, drain;
    logic   load_m_in, load_m_k, load_k;

    assign in_ready  = rdy_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && rdy_q;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_nx  = state;
        load_m_in = 1'b0;
        load_m_k  = 1'b0;
        load_k    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_m_in = 1'b1;
                    state_nx  = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    load_k   = 1'b1;
                    state_nx = TWO;
                end else if (drain) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    load_m_k = 1'b1;
                    state_nx = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx != TWO);
        end
    end

    // M keeps its last value when drained, so out_* hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            k_q <= '0;
        end else begin
            if (load_m_in)     m_q <= dec;
            else if (load_m_k) m_q <= k_q;
            if (load_k)        k_q <= dec;
        end
    end

    assign out_imm     = m_q.imm;
    assign out_fmt     = m_q.fmt;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance and a 64-bit RV64_OPS instance
// share the input side. Table vectors stream back-to-back with out_ready=1;
// hand-written sequences cover backpressure and asynchronous reset.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_inst   = inst;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // checks the 32-bit instance's output side and in_ready
    task automatic chk_out(input string tag, input logic v, input logic [31:0] imm,
                           input logic [2:0] fmt, input logic ill, input logic rdy);
        chk({tag, ".out_valid"},   64'(out_valid),   64'(v));
        chk({tag, ".out_imm"},     64'(out_imm),     64'(imm));
        chk({tag, ".out_fmt"},     64'(out_fmt),     64'(fmt));
        chk({tag, ".out_illegal"}, 64'(out_illegal), 64'(ill));
        chk({tag, ".in_ready"},    64'(in_ready),    64'(rdy));
    endtask

    initial begin
        //         inst          imm32         f32   i32   imm64                  f64   i64
        vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // ADDI -1
        vt[1]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0}; // LUI
        vt[2]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // LUI neg
        vt[3]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0}; // SW -4
        vt[4]  = '{32'h00000463, 32'h00000008, 3'd3, 1'b0, 64'h0000000000000008, 3'd3, 1'b0}; // BEQ +8
        vt[5]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0}; // JAL -4
        vt[6]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0}; // ADD
        vt[7]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1}; // zero word
        vt[8]  = '{32'h00412083, 32'h00000004, 3'd1, 1'b0, 64'h0000000000000004, 3'd1, 1'b0}; // LW +4
        vt[9]  = '{32'hFFF0809B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // ADDIW
        vt[10] = '{32'h002080BB, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0}; // ADDW
        vt[11] = '{32'hFFFFF117, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0}; // AUIPC
        vt[12] = '{32'h00008067, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0}; // JALR
        vt[13] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0}; // ECALL
        vt[14] = '{32'hFFFFFFFC, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1}; // [1:0]!=11
        vt[15] = '{32'h00110423, 32'h00000008, 3'd2, 1'b0, 64'h0000000000000008, 3'd2, 1'b0}; // SB +8
        vt[16] = '{32'hFE209EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0}; // BNE -4

        // ---- reset state ----
        #12;
        chk_out("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
        chk("reset.out_imm64", out_imm64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- back-to-back table stream, one result per cycle ----
        for (int i = 0; i < 17; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(1'b1, vt[i].inst, 1'b1);
            chk_out(tag, 1'b1, vt[i].imm32, vt[i].fmt32, vt[i].ill32, 1'b1);
            chk({tag, ".out_valid64"},   64'(out_valid64),   64'h1);
            chk({tag, ".out_imm64"},     out_imm64,          vt[i].imm64);
            chk({tag, ".out_fmt64"},     64'(out_fmt64),     64'(vt[i].fmt64));
            chk({tag, ".out_illegal64"}, 64'(out_illegal64), 64'(vt[i].ill64));
        end
        // drain; outputs hold the last word
        drive(1'b0, 32'h0, 1'b1);
        chk_out("idle_hold", 1'b0, vt[16].imm32, vt[16].fmt32, vt[16].ill32, 1'b1);

        // ---- backpressure: A, B accepted, C held upstream ----
        drive(1'b1, 32'hFFF00093, 1'b0);                                   // A
        chk_out("bp_a", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b1);
        drive(1'b1, 32'h123450B7, 1'b0);                                   // B -> skid
        chk_out("bp_b", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'hFE112E23, 1'b0);                               // C waits
            chk_out($sformatf("bp_hold%0d", c), 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0);
        end
        drive(1'b1, 32'hFE112E23, 1'b1);                                   // A drained
        chk_out("bp_out_b", 1'b1, 32'h12345000, 3'd4, 1'b0, 1'b1);
        drive(1'b1, 32'hFE112E23, 1'b1);                                   // C in, B out
        chk_out("bp_out_c", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk_out("bp_empty", 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b1);

        // ---- asynchronous reset while TWO ----
        drive(1'b1, 32'h00000463, 1'b0);
        drive(1'b1, 32'h00412083, 1'b0);
        chk_out("pre_rst", 1'b1, 32'h00000008, 3'd3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'hFFDFF06F, 1'b1);
        chk_out("post_rst", 1'b1, 32'hFFFFFFFC, 3'd5, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        chk_out("post_rst_empty", 1'b0, 32'hFFFFFFFC, 3'd5, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
